// File: rtl/cram_loader.sv
// CRAM write-side loader: packs three 36-bit diagnostic chunks into one 84-bit
// control-RAM word and writes it with an auto-incrementing address.
module cram_loader #(
  parameter int ADDR_W  = 11,
  parameter int CRAM_W  = 84,
  parameter int CHUNK_W = 36
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adr_load,
  input  logic [ADDR_W-1:0] adr_in,
  input  logic              diag_valid,
  output logic              diag_ready,
  input  logic [CHUNK_W-1:0] diag_data,
  output logic              cram_we,
  output logic [ADDR_W-1:0] cram_addr,
  output logic [CRAM_W-1:0] cram_din,
  output logic [ADDR_W:0]   wcount,
  output logic              wrapped
);

  // Buses are declared descending; the machine's bit 0 (MSB) is the top bit here,
  // so chunk 0 lands in the most significant 36 bits of the word.
  localparam int ASM_W = 2 * CHUNK_W;
  localparam int LOW_W = CRAM_W - ASM_W;
  localparam logic [ADDR_W:0] WCOUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2,
    WR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ASM_W-1:0]   asm_q;
  logic               accept;

  assign diag_ready = (state_q != WR) && !adr_load;
  assign accept     = diag_valid && diag_ready;
  // Decoded straight from the state so reset removes the strobe without a clock.
  assign cram_we    = (state_q == WR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= C0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    if (state_q == WR) begin
      state_d = C0;
    end else if (adr_load) begin
      state_d = C0;
    end else if (accept) begin
      unique case (state_q)
        C0:      state_d = C1;
        C1:      state_d = C2;
        C2:      state_d = WR;
        default: state_d = C0;
      endcase
    end
  end

  // Chunk assembly; the last chunk goes straight into the output register
  // together with the two held chunks, so cram_din is stable for the WR cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q    <= '0;
      cram_din <= '0;
    end else if (accept) begin
      unique case (state_q)
        C0:      asm_q[ASM_W-1 -: CHUNK_W]   <= diag_data;
        C1:      asm_q[CHUNK_W-1 -: CHUNK_W] <= diag_data;
        C2:      cram_din <= {asm_q, diag_data[LOW_W-1:0]};
        default: ;
      endcase
    end
  end

  // Address, word count and wrap flag. An address load during WR lets the
  // current write finish at the old address and then replaces the increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cram_addr <= '0;
      wcount    <= '0;
      wrapped   <= 1'b0;
    end else if (adr_load) begin
      cram_addr <= adr_in;
      wcount    <= '0;
      wrapped   <= 1'b0;
    end else if (state_q == WR) begin
      cram_addr <= cram_addr + 1'b1;
      if (wcount != WCOUNT_MAX) begin
        wcount <= wcount + 1'b1;
      end
      if (&cram_addr) begin
        wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// Self-checking bench for cram_loader: directed scenarios plus random traffic,
// all compared against a chunk-counting reference model.
module tb_cram_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adr_load;
  logic [10:0] adr_in;
  logic        diag_valid;
  logic        diag_ready;
  logic [35:0] diag_data;
  logic        cram_we;
  logic [10:0] cram_addr;
  logic [83:0] cram_din;
  logic [11:0] wcount;
  logic        wrapped;

  cram_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adr_load   (adr_load),
    .adr_in     (adr_in),
    .diag_valid (diag_valid),
    .diag_ready (diag_ready),
    .diag_data  (diag_data),
    .cram_we    (cram_we),
    .cram_addr  (cram_addr),
    .cram_din   (cram_din),
    .wcount     (wcount),
    .wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a word buffer that fills with chunks, then one write cycle.
  int unsigned m_addr;
  int unsigned m_cnt;
  bit          m_wrapped;
  int          m_nchunks;
  bit          m_pending;
  logic [83:0] m_c0, m_c1;
  logic [83:0] m_din;
  int          cycle;
  int          wr_addrs[$];
  int          wr_cycles[$];

  task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_cnt = 0; m_wrapped = 0; m_nchunks = 0; m_pending = 0;
    m_c0 = '0; m_c1 = '0; m_din = '0;
  endtask

  task automatic check_outputs();
    check("cram_we",   cram_we,   m_pending);
    check("cram_addr", cram_addr, m_addr);
    check("wcount",    wcount,    m_cnt);
    check("wrapped",   wrapped,   m_wrapped);
    check("cram_din",  cram_din,  m_din);
    if (cram_we === 1'b1) begin
      wr_addrs.push_back(int'(cram_addr));
      wr_cycles.push_back(cycle);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit ld, input logic [10:0] a, input bit v, input logic [35:0] d);
    adr_load = ld; adr_in = a; diag_valid = v; diag_data = d;
    #1;
    check("diag_ready", diag_ready, (!m_pending && !ld));
    @(posedge clk);
    if (m_pending) begin
      m_pending = 0;
      m_nchunks = 0;
      if (ld) begin
        m_addr = a; m_cnt = 0; m_wrapped = 0;
      end else begin
        if (m_addr == 2047) m_wrapped = 1;
        m_addr = (m_addr + 1) % 2048;
        if (m_cnt < 2048) m_cnt++;
      end
    end else if (ld) begin
      m_addr = a; m_cnt = 0; m_wrapped = 0; m_nchunks = 0;
    end else if (v) begin
      if (m_nchunks == 0) m_c0 = 84'(d);
      else if (m_nchunks == 1) m_c1 = 84'(d);
      else begin
        m_din = (m_c0 << 48) | (m_c1 << 12) | (84'(d) & 84'hFFF);
        m_pending = 1;
      end
      m_nchunks++;
    end
    cycle++;
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [35:0] rnd36();
    return {$urandom_range(15, 0), $urandom()};
  endfunction

  initial begin
    reset_n = 1'b0; adr_load = 1'b0; adr_in = '0; diag_valid = 1'b0; diag_data = '0;
    cycle = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_we",     cram_we,    1'b0);
    check("reset_addr",   cram_addr,  11'h000);
    check("reset_din",    cram_din,   84'h0);
    check("reset_wcount", wcount,     12'h000);
    check("reset_wrap",   wrapped,    1'b0);
    reset_n = 1'b1;

    // Single word at 0x010 with fixed data.
    step(1, 11'h010, 0, '0);
    wr_addrs.delete(); wr_cycles.delete();
    step(0, '0, 1, 36'h123456789);
    step(0, '0, 1, 36'hABCDEF012);
    step(0, '0, 1, 36'h000000FED);
    check("t1_we",   cram_we,  1'b1);
    check("t1_din",  cram_din, 84'h123456789ABCDEF012FED);
    check("t1_addr_wr", cram_addr, 11'h010);
    step(0, '0, 0, '0);
    check("t1_addr_after", cram_addr, 11'h011);
    check("t1_wcount", wcount, 12'd1);
    check("t1_nwrites", wr_addrs.size(), 1);

    // Two back-to-back words across the 2047 -> 0 wrap.
    step(1, 11'h7FF, 0, '0);
    wr_addrs.delete(); wr_cycles.delete();
    for (int i = 0; i < 8; i++) step(0, '0, 1, rnd36());
    check("t2_nwrites", wr_addrs.size(), 2);
    if (wr_addrs.size() == 2) begin
      check("t2_addr0", wr_addrs[0], 11'h7FF);
      check("t2_addr1", wr_addrs[1], 11'h000);
      check("t2_gap",   wr_cycles[1] - wr_cycles[0], 4);
    end
    check("t2_wrapped", wrapped, 1'b1);
    check("t2_wcount",  wcount,  12'd2);

    // Partial word discarded by a new address load.
    step(1, 11'h100, 0, '0);
    wr_addrs.delete(); wr_cycles.delete();
    step(0, '0, 1, rnd36());
    step(0, '0, 1, rnd36());
    step(1, 11'h200, 0, '0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, rnd36());
    check("t3_nwrites", wr_addrs.size(), 1);
    if (wr_addrs.size() == 1) check("t3_addr", wr_addrs[0], 11'h200);
    check("t3_wcount", wcount, 12'd1);

    // Address load collides with a valid chunk: the chunk must not be taken.
    step(1, 11'h055, 1, rnd36());
    check("t4_addr", cram_addr, 11'h055);
    wr_addrs.delete(); wr_cycles.delete();
    for (int i = 0; i < 4; i++) step(0, '0, 1, rnd36());
    check("t4_nwrites", wr_addrs.size(), 1);
    if (wr_addrs.size() == 1) check("t4_wr_addr", wr_addrs[0], 11'h055);

    // Reset during the write cycle, between clock edges.
    step(1, 11'h321, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, rnd36());
    check("t5_in_wr", cram_we, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_we_async", cram_we,   1'b0);
    check("t5_addr",     cram_addr, 11'h000);
    check("t5_din",      cram_din,  84'h0);
    check("t5_wcount",   wcount,    12'd0);
    check("t5_wrapped",  wrapped,   1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    wr_addrs.delete(); wr_cycles.delete();
    step(0, '0, 1, 36'h111111111);
    step(0, '0, 1, 36'h222222222);
    step(0, '0, 1, 36'h333333333);
    check("t5_din_after", cram_din, 84'h111111111222222222333);
    step(0, '0, 0, '0);
    check("t5_nwrites", wr_addrs.size(), 1);
    if (wr_addrs.size() == 1) check("t5_wr_addr", wr_addrs[0], 11'h000);

    // 2049 words from address 0: count saturates, address wraps to 1.
    step(1, 11'h000, 0, '0);
    for (int i = 0; i < 2049 * 4; i++) step(0, '0, 1, rnd36());
    check("t6_wcount",  wcount,    12'd2048);
    check("t6_wrapped", wrapped,   1'b1);
    check("t6_addr",    cram_addr, 11'h001);

    // Random traffic with sporadic address loads.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(19, 0) == 0), 11'($urandom()),
           ($urandom_range(9, 0) < 7), rnd36());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
